// File: rtl/water_tank_model.sv
// Time-accurate water tank responder for the washing-machine controller.
// Integrates active-low fill/drain valve commands into a saturating level and reports full/empty/overflow.
module water_tank_model #(
  parameter int unsigned TICK_DIV   = 100,
  parameter int unsigned LEVEL_MAX  = 15,
  parameter int unsigned FILL_STEP  = 1,
  parameter int unsigned DRAIN_STEP = 2,
  parameter int unsigned OVF_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_fill_n,
  input  logic       i_drain_n,
  input  logic       i_ovf_clr,
  output logic       o_water_full_n,
  output logic       o_water_empty_n,
  output logic [7:0] o_level,
  output logic [1:0] o_state,
  output logic       o_overflow
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  localparam logic [1:0] ST_HOLD     = 2'b00;
  localparam logic [1:0] ST_FILL     = 2'b01;
  localparam logic [1:0] ST_DRAIN    = 2'b10;
  localparam logic [1:0] ST_CONFLICT = 2'b11;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [8:0]    LMAX9      = 9'(LEVEL_MAX);
  localparam logic [8:0]    FSTEP9     = 9'(FILL_STEP);
  localparam logic [8:0]    DSTEP9     = 9'(DRAIN_STEP);
  localparam logic [7:0]    LMAX8      = 8'(LEVEL_MAX);
  localparam logic [7:0]    OVF_LIMIT  = 8'(OVF_TICKS);

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    level;
  logic [7:0]    level_next;
  logic [7:0]    ovf_cnt;
  logic [7:0]    ovf_cnt_inc;
  logic          overflow;
  logic          running;
  logic          tick;
  logic          at_full;
  logic          ovf_inc;
  logic          ovf_set;
  logic [8:0]    fill_sum;
  logic [8:0]    drain_diff;

  // Bit 0 is the fill request, bit 1 the drain request, so the encoding falls out directly.
  assign next_state = {~i_drain_n, ~i_fill_n};

  assign running = (state == ST_FILL) || (state == ST_DRAIN);
  assign tick    = running && (tick_cnt == TICK_LAST);
  assign at_full = (level == LMAX8);

  // Nine-bit arithmetic keeps the carry/borrow visible so the level saturates instead of wrapping.
  assign fill_sum   = {1'b0, level} + FSTEP9;
  assign drain_diff = {1'b0, level} - DSTEP9;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    level_next = level;
    if (tick) begin
      case (state)
        ST_FILL:  level_next = (fill_sum > LMAX9) ? LMAX8 : fill_sum[7:0];
        ST_DRAIN: level_next = drain_diff[8] ? 8'd0 : drain_diff[7:0];
        default:  level_next = level;
      endcase
    end
  end

  assign ovf_inc     = tick && (state == ST_FILL) && at_full;
  assign ovf_cnt_inc = (ovf_cnt == 8'hFF) ? ovf_cnt : ovf_cnt + 8'd1;
  assign ovf_set     = ovf_inc && (ovf_cnt_inc >= OVF_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HOLD;
    end else begin
      state <= next_state;
    end
  end

  // A command change or a non-running state discards the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if ((next_state != state) || !running || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 8'd0;
    end else begin
      level <= level_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 8'd0;
    end else if ((state != ST_FILL) || !at_full) begin
      ovf_cnt <= 8'd0;
    end else if (ovf_inc) begin
      ovf_cnt <= ovf_cnt_inc;
    end
  end

  // Clear has priority over a coincident set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (i_ovf_clr) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end
  end

  assign o_level         = level;
  assign o_state         = state;
  assign o_overflow      = overflow;
  assign o_water_full_n  = ~at_full;
  assign o_water_empty_n = (level != 8'd0);

endmodule

// File: tb/tb_water_tank_model.sv
// Self-checking bench for water_tank_model: directed test-plan steps followed by
// randomized valve commands compared against a behavioural tank model.
module tb_water_tank_model;

  localparam int TICK_DIV   = 4;
  localparam int LEVEL_MAX  = 3;
  localparam int FILL_STEP  = 1;
  localparam int DRAIN_STEP = 2;
  localparam int OVF_TICKS  = 2;

  localparam logic [1:0] S_HOLD = 2'b00, S_FILL = 2'b01, S_DRAIN = 2'b10, S_CONF = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fill_n;
  logic       drain_n;
  logic       ovf_clr;
  logic       water_full_n;
  logic       water_empty_n;
  logic [7:0] level;
  logic [1:0] state;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: level, the command currently held, how many edges it has been
  // held, consecutive fill ticks spent at full, and the sticky fault.
  int         m_level;
  logic [1:0] m_cmd;
  int         m_run;
  int         m_full_ticks;
  logic       m_ovf;

  water_tank_model #(
    .TICK_DIV  (TICK_DIV),
    .LEVEL_MAX (LEVEL_MAX),
    .FILL_STEP (FILL_STEP),
    .DRAIN_STEP(DRAIN_STEP),
    .OVF_TICKS (OVF_TICKS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fill_n       (fill_n),
    .i_drain_n      (drain_n),
    .i_ovf_clr      (ovf_clr),
    .o_water_full_n (water_full_n),
    .o_water_empty_n(water_empty_n),
    .o_level        (level),
    .o_state        (state),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_level      = 0;
    m_cmd        = S_HOLD;
    m_run        = 0;
    m_full_ticks = 0;
    m_ovf        = 1'b0;
  endtask

  // One clock edge of the tank as described in plain terms: a held fill/drain command
  // produces a level change every TICK_DIV edges after it was first sampled.
  task automatic model_edge(input logic f_n, input logic d_n, input logic clr, input logic r_n);
    logic [1:0] cmd;
    bit         is_tick;
    bit         set_ovf;
    if (!r_n) begin
      model_reset();
    end else begin
      cmd     = {~d_n, ~f_n};
      is_tick = ((m_cmd == S_FILL) || (m_cmd == S_DRAIN)) && (((m_run + 1) % TICK_DIV) == 0);
      set_ovf = 1'b0;
      if ((m_cmd != S_FILL) || (m_level < LEVEL_MAX)) begin
        m_full_ticks = 0;
      end else if (is_tick) begin
        m_full_ticks++;
        set_ovf = (m_full_ticks >= OVF_TICKS);
      end
      if (is_tick && m_cmd == S_FILL) begin
        m_level = (m_level + FILL_STEP > LEVEL_MAX) ? LEVEL_MAX : m_level + FILL_STEP;
      end else if (is_tick && m_cmd == S_DRAIN) begin
        m_level = (m_level - DRAIN_STEP < 0) ? 0 : m_level - DRAIN_STEP;
      end
      if (clr) m_ovf = 1'b0;
      else if (set_ovf) m_ovf = 1'b1;
      if (cmd == m_cmd) begin
        m_run++;
      end else begin
        m_cmd = cmd;
        m_run = 0;
      end
    end
  endtask

  // Advance one edge; inputs are captured before the edge, outputs settle by #1 after it.
  task automatic step();
    logic f, d, c, r;
    f = fill_n;
    d = drain_n;
    c = ovf_clr;
    r = rst_n;
    @(posedge clk);
    model_edge(f, d, c, r);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".level"},   level,                 8'(m_level));
    check({tag, ".state"},   {6'd0, state},         {6'd0, m_cmd});
    check({tag, ".full_n"},  {7'd0, water_full_n},  {7'd0, (m_level != LEVEL_MAX)});
    check({tag, ".empty_n"}, {7'd0, water_empty_n}, {7'd0, (m_level != 0)});
    check({tag, ".ovf"},     {7'd0, overflow},      {7'd0, m_ovf});
  endtask

  initial begin
    rst_n   = 1'b0;
    fill_n  = 1'b1;
    drain_n = 1'b1;
    ovf_clr = 1'b0;
    model_reset();
    #2;
    check("por.level", level, 8'd0);
    check("por.empty_n", {7'd0, water_empty_n}, 8'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_model("idle");

    // Fill to full, then keep filling into overflow.
    fill_n = 1'b0;
    for (int e = 0; e <= 20; e++) begin
      step();
      check_model("fill");
      if (e == 0)  check("fill.e0.state", {6'd0, state}, {6'd0, S_FILL});
      if (e == 3)  check("fill.e3.level", level, 8'd0);
      if (e == 4)  check("fill.e4.level", level, 8'd1);
      if (e == 4)  check("fill.e4.empty_n", {7'd0, water_empty_n}, 8'd1);
      if (e == 8)  check("fill.e8.level", level, 8'd2);
      if (e == 11) check("fill.e11.full_n", {7'd0, water_full_n}, 8'd1);
      if (e == 12) check("fill.e12.level", level, 8'd3);
      if (e == 12) check("fill.e12.full_n", {7'd0, water_full_n}, 8'd0);
      if (e == 16) check("ovf.e16.level", level, 8'd3);
      if (e == 16) check("ovf.e16.flag", {7'd0, overflow}, 8'd0);
      if (e == 20) check("ovf.e20.flag", {7'd0, overflow}, 8'd1);
    end

    fill_n = 1'b1;
    for (int e = 0; e < 3; e++) step();
    check("ovf.sticky", {7'd0, overflow}, 8'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf.clear", {7'd0, overflow}, 8'd0);
    check_model("ovf.clear");

    // Saturating drain from full.
    drain_n = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      step();
      check_model("drain");
      if (e == 4)  check("drain.e4.level", level, 8'd1);
      if (e == 8)  check("drain.e8.level", level, 8'd0);
      if (e == 8)  check("drain.e8.empty_n", {7'd0, water_empty_n}, 8'd0);
      if (e == 12) check("drain.e12.level", level, 8'd0);
    end
    drain_n = 1'b1;
    step();

    // Reach level 1, then hold both commands.
    fill_n = 1'b0;
    for (int e = 0; e <= 4; e++) step();
    check("conf.pre.level", level, 8'd1);
    drain_n = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      check("conf.state", {6'd0, state}, {6'd0, S_CONF});
      check("conf.level", level, 8'd1);
    end
    drain_n = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      step();
      check_model("conf.exit");
      if (e == 0) check("conf.exit.e0.state", {6'd0, state}, {6'd0, S_FILL});
      if (e == 3) check("conf.exit.e3.level", level, 8'd1);
      if (e == 4) check("conf.exit.e4.level", level, 8'd2);
    end

    // Empty the tank, then an interrupted fill.
    fill_n  = 1'b1;
    drain_n = 1'b0;
    for (int e = 0; e <= 4; e++) step();
    drain_n = 1'b1;
    step();
    check("intr.start.level", level, 8'd0);
    fill_n = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      if (e == 4) check("intr.e4.level", level, 8'd1);
    end
    fill_n = 1'b1;
    for (int e = 0; e < 3; e++) step();
    fill_n = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      step();
      check_model("intr");
      if (e == 3) check("intr.e3p.level", level, 8'd1);
      if (e == 4) check("intr.e4p.level", level, 8'd2);
    end

    // Asynchronous reset in the middle of a fill at level 2.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst.level", level, 8'd0);
    check("rst.state", {6'd0, state}, 8'd0);
    check("rst.full_n", {7'd0, water_full_n}, 8'd1);
    check("rst.empty_n", {7'd0, water_empty_n}, 8'd0);
    check("rst.ovf", {7'd0, overflow}, 8'd0);
    fill_n = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check_model("rst.release");

    // Randomized commands, occasional clears and resets, against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) fill_n  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) drain_n = ($urandom_range(0, 1) == 0);
      ovf_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("rand.rst");
        step();
        rst_n = 1'b1;
      end
      step();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
